ifu_pc_redirect: RTL and testbench

- Fetch-side partner of the ID-stage jump stall logic. Consumes `pipe_valid` and the resolved jump request and target from ID.
- Owns the program counter and the IF/ID pipeline register:
  - holds both while ID stalls;
  - redirects the PC on a taken JAL/JALR;
  - injects NOP bubbles into IF/ID so that wrong-path fetches never reach ID.
- Sits between the instruction-memory address port and the ID stage.

---
 rtl/ifu_pc_redirect_pkg.sv | 19 +
 rtl/ifu_pc_redirect_flush_counter.sv | 31 +++
 rtl/ifu_pc_redirect.sv | 140 ++++++++++++++
 tb/tb_ifu_pc_redirect.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pc_redirect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pc_redirect_pkg
// Purpose  : Shared constants and FSM encoding for the fetch-side PC redirect
// Revision : 1.0  initial release
// ============================================================================
package ifu_pc_redirect_pkg;

  localparam int          DATAWIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/ifu_pc_redirect_flush_counter.sv
`default_nettype none
// ============================================================================
// Module   : ifu_flush_counter
// Purpose  : 2-bit loadable down-counter tracking remaining redirect bubbles
// Revision : 1.0  initial release
// ============================================================================
module ifu_flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] count,
  output logic       done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 2'd0)) begin
      count <= count - 2'd1;
    end
  end

  // Last bubble is being issued when the count reaches one
  assign done = (count == 2'd1);

endmodule
`default_nettype wire

// File: rtl/ifu_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pc_redirect
// Purpose  : PC and IF/ID register owner with stall hold, jump redirect and
//            bubble injection. Optional macro IFU_REDIRECT_STATS_EN adds a
//            saturating redirect counter output.
// Revision : 1.0  initial release
// ============================================================================
module ifu_pc_redirect #(
  parameter int                   DATAWIDTH    = ifu_pc_redirect_pkg::DATAWIDTH,
  parameter logic [DATAWIDTH-1:0] RESET_PC     = '0,
  parameter int                   FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid,
  input  logic                 jump_req,
  input  logic [DATAWIDTH-1:0] jump_target,
  input  logic [DATAWIDTH-1:0] imem_instr,
  output logic [DATAWIDTH-1:0] imem_addr,
  output logic [DATAWIDTH-1:0] ifid_pc,
  output logic [DATAWIDTH-1:0] ifid_instr,
  output logic                 ifid_valid
`ifdef IFU_REDIRECT_STATS_EN
  ,
  output logic [15:0]          redirect_count
`endif
);

  import ifu_pc_redirect_pkg::NOP_INSTR;
  import ifu_pc_redirect_pkg::PC_INC;
  import ifu_pc_redirect_pkg::fsm_state_t;
  import ifu_pc_redirect_pkg::RUN;
  import ifu_pc_redirect_pkg::FLUSH;

  localparam logic [DATAWIDTH-1:0] NOP_W      = DATAWIDTH'(NOP_INSTR);
  localparam logic [DATAWIDTH-1:0] PC_STEP    = DATAWIDTH'(PC_INC);
  localparam logic [1:0]           FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  fsm_state_t           state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [DATAWIDTH-1:0] ifid_pc_d, ifid_instr_d;
  logic                 ifid_valid_d;
  logic                 redirect;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 cnt_done;
  logic [1:0]           cnt_value;
  logic                 unused_target_lsbs;

  // ifid_valid gates acceptance so a jump held across cycles redirects once
  assign redirect           = jump_req & pipe_valid & ifid_valid;
  assign cnt_en             = pipe_valid & (state_q == FLUSH);
  assign unused_target_lsbs = ^{jump_target[1:0], cnt_value};
  assign imem_addr          = pc_q;

  ifu_flush_counter u_flush_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (FLUSH_LOAD),
    .count    (cnt_value),
    .done     (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc;
    ifid_instr_d = ifid_instr;
    ifid_valid_d = ifid_valid;
    cnt_load     = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d         = {jump_target[DATAWIDTH-1:2], 2'b00};
          ifid_pc_d    = '0;
          ifid_instr_d = NOP_W;
          ifid_valid_d = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d  = FLUSH;
            cnt_load = 1'b1;
          end
        end else if (pipe_valid) begin
          pc_d         = pc_q + PC_STEP;
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_instr;
          ifid_valid_d = 1'b1;
        end
      end
      FLUSH: begin
        // PC parks on the target while the remaining bubbles drain
        if (pipe_valid) begin
          ifid_pc_d    = '0;
          ifid_instr_d = NOP_W;
          ifid_valid_d = 1'b0;
          if (cnt_done) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_W;
      ifid_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_pc    <= ifid_pc_d;
      ifid_instr <= ifid_instr_d;
      ifid_valid <= ifid_valid_d;
    end
  end

`ifdef IFU_REDIRECT_STATS_EN
  logic [15:0] redirect_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count_q <= 16'd0;
    end else if (redirect && (redirect_count_q != 16'hFFFF)) begin
      redirect_count_q <= redirect_count_q + 16'd1;
    end
  end

  assign redirect_count = redirect_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_pc_redirect
// Purpose  : Self-checking bench for ifu_pc_redirect (FLUSH_CYCLES 1 and 2)
// Revision : 1.0  initial release
// ============================================================================
module tb_ifu_pc_redirect;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic        jump_req;
  logic [31:0] jump_target;
  logic [31:0] addr1, addr2, instr1, instr2;
  logic [31:0] ipc1, ipc2, ins1, ins2;
  logic        v1, v2;
`ifdef IFU_REDIRECT_STATS_EN
  logic [15:0] cnt1, cnt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Synthetic instruction memory: distinct, address-dependent content
  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  assign instr1 = ifn(addr1);
  assign instr2 = ifn(addr2);

  ifu_pc_redirect #(.DATAWIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .jump_req(jump_req),
    .jump_target(jump_target), .imem_instr(instr1), .imem_addr(addr1),
    .ifid_pc(ipc1), .ifid_instr(ins1), .ifid_valid(v1)
`ifdef IFU_REDIRECT_STATS_EN
    , .redirect_count(cnt1)
`endif
  );

  ifu_pc_redirect #(.DATAWIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .jump_req(jump_req),
    .jump_target(jump_target), .imem_instr(instr2), .imem_addr(addr2),
    .ifid_pc(ipc2), .ifid_instr(ins2), .ifid_valid(v2)
`ifdef IFU_REDIRECT_STATS_EN
    , .redirect_count(cnt2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC, IF/ID contents, bubbles still owed, redirect tally
  int          fc [2] = '{1, 2};
  logic [31:0] m_pc [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_ins [2];
  logic        m_v [2];
  int          m_rem [2];
  int          m_cnt [2];
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = 32'h0; m_ipc[k] = 32'h0; m_ins[k] = NOP; m_v[k] = 1'b0;
        m_rem[k] = 0; m_cnt[k] = 0;
      end else if (pipe_valid) begin
        if (m_rem[k] > 0) begin
          m_ipc[k] = 32'h0; m_ins[k] = NOP; m_v[k] = 1'b0;
          m_rem[k] = m_rem[k] - 1;
        end else if (jump_req && m_v[k]) begin
          m_ipc[k] = 32'h0; m_ins[k] = NOP; m_v[k] = 1'b0;
          m_pc[k]  = jump_target & ~32'h3;
          m_rem[k] = fc[k] - 1;
          if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
        end else begin
          m_ipc[k] = m_pc[k]; m_ins[k] = ifn(m_pc[k]); m_v[k] = 1'b1;
          m_pc[k]  = m_pc[k] + 32'd4;
        end
      end
    end
    if (rst) m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m1_addr", addr1, m_pc[0]);
      chk("m1_ifid_pc", ipc1, m_ipc[0]);
      chk("m1_ifid_instr", ins1, m_ins[0]);
      chk("m1_ifid_valid", {31'b0, v1}, {31'b0, m_v[0]});
      chk("m2_addr", addr2, m_pc[1]);
      chk("m2_ifid_pc", ipc2, m_ipc[1]);
      chk("m2_ifid_instr", ins2, m_ins[1]);
      chk("m2_ifid_valid", {31'b0, v2}, {31'b0, m_v[1]});
`ifdef IFU_REDIRECT_STATS_EN
      chk("m1_count", {16'b0, cnt1}, 32'(m_cnt[0]));
      chk("m2_count", {16'b0, cnt2}, 32'(m_cnt[1]));
`endif
    end
  end

  task automatic step(input logic r, input logic pv, input logic j, input logic [31:0] t);
    rst = r; pipe_valid = pv; jump_req = j; jump_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; jump_req = 1'b0; jump_target = 32'h0;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_addr", addr1, 32'h0);
    chk("rst_valid", {31'b0, v1}, 32'h0);
    chk("rst_ifid_pc", ipc1, 32'h0);
    chk("rst_ifid_instr", ins1, NOP);

    step(0, 1, 0, 0);
    chk("adv_addr4", addr1, 32'h4);
    chk("adv_valid", {31'b0, v1}, 32'h1);
    chk("adv_ifid_pc0", ipc1, 32'h0);
    chk("adv_ifid_instr0", ins1, ifn(32'h0));
    step(0, 1, 0, 0);
    chk("adv_addr8", addr1, 32'h8);
    step(0, 1, 0, 0);
    chk("adv_addr12", addr1, 32'hC);
    step(0, 1, 0, 0);
    chk("adv_addr16", addr1, 32'h10);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("stall_addr", addr1, 32'h10);
      chk("stall_ifid_pc", ipc1, 32'hC);
    end
    step(0, 1, 0, 0);
    chk("resume_addr", addr1, 32'h14);
    chk("resume_ifid_pc", ipc1, 32'h10);

    step(0, 1, 1, 32'h100);
    chk("jal1_addr", addr1, 32'h100);
    chk("jal1_valid", {31'b0, v1}, 32'h0);
    chk("jal2_addr", addr2, 32'h100);
    step(0, 1, 1, 32'h100);
    chk("jal1_ifid_pc", ipc1, 32'h100);
    chk("jal1_valid_after", {31'b0, v1}, 32'h1);
    chk("jal1_no_second", addr1, 32'h104);
    chk("jal2_bubble", {31'b0, v2}, 32'h0);
    chk("jal2_hold_pc", addr2, 32'h100);
    step(0, 1, 0, 0);
    chk("jal2_ifid_pc", ipc2, 32'h100);
    chk("jal2_valid", {31'b0, v2}, 32'h1);

    step(0, 1, 1, 32'h203);
    chk("jalr_align1", addr1, 32'h200);
    chk("jalr_align2", addr2, 32'h200);
    step(0, 0, 0, 0);
    chk("jalr2_stall_bubble", {31'b0, v2}, 32'h0);
    step(0, 1, 0, 0);
    chk("jalr2_still_bubble", {31'b0, v2}, 32'h0);
    chk("jalr2_pc_hold", addr2, 32'h200);
    chk("jalr1_ifid_pc", ipc1, 32'h200);
    step(0, 1, 0, 0);
    chk("jalr2_ifid_pc", ipc2, 32'h200);
    chk("jalr2_valid", {31'b0, v2}, 32'h1);

    step(0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_setup", addr1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wrap_addr", addr1, 32'h0);
    step(0, 1, 0, 0);
    chk("wrap_addr2", addr2, 32'h0);

    step(0, 1, 1, 32'h40);
    chk("flush_enter", addr2, 32'h40);
`ifdef IFU_REDIRECT_STATS_EN
    chk("count_before_rst", {16'b0, cnt2}, 32'd4);
`endif
    step(1, 1, 0, 0);
    chk("rst_in_flush_addr", addr2, 32'h0);
    chk("rst_in_flush_valid", {31'b0, v2}, 32'h0);
    chk("rst_in_flush_instr", ins2, NOP);
`ifdef IFU_REDIRECT_STATS_EN
    chk("count_after_rst", {16'b0, cnt2}, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), t);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
